// File: rtl/nn_cfg_loader.sv
// nn_cfg_loader: converts a header + payload word stream into config
// register-file writes, with sticky bad-header error and abort support.
module nn_cfg_loader #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 2,
  parameter logic [3:0]  MAGIC  = 4'hC
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_abort,
  input  logic              i_err_clr,
  output logic [DATA_W-1:0] o_cfg,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wr_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned MAGIC_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Datapath registers and their next values.
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_remaining;
  logic [DATA_W-1:0] r_cfg;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr_en;
  logic              r_done;
  logic              r_err;

  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [ADDR_W-1:0] w_remaining_nxt;
  logic [DATA_W-1:0] w_cfg_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_wr_en_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;

  // Handshake and header field decode.
  logic               w_ready;
  logic               w_accept;
  logic [MAGIC_W-1:0] w_hdr_magic;
  logic [ADDR_W-1:0]  w_hdr_start;
  logic [ADDR_W-1:0]  w_hdr_cnt_m1;
  logic               w_hdr_ok;

  assign w_ready      = ((r_state == S_IDLE) || (r_state == S_LOAD)) && !i_abort;
  assign w_accept     = i_valid && w_ready;
  assign w_hdr_magic  = i_data[DATA_W-1 -: MAGIC_W];
  assign w_hdr_start  = i_data[ADDR_W-1:0];
  assign w_hdr_cnt_m1 = i_data[2*ADDR_W-1:ADDR_W];
  assign w_hdr_ok     = (w_hdr_magic == MAGIC);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_hdr_ok ? S_LOAD : S_ERR;
        end
      end
      S_LOAD: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_accept && (r_remaining == '0)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (i_err_clr) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic: next values for the registered write port and flags.
  always_comb begin
    w_ptr_nxt       = r_ptr;
    w_remaining_nxt = r_remaining;
    w_cfg_nxt       = r_cfg;
    w_addr_nxt      = r_addr;
    w_wr_en_nxt     = 1'b0;
    w_done_nxt      = 1'b0;
    w_err_nxt       = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_hdr_ok) begin
            w_ptr_nxt       = w_hdr_start;
            w_remaining_nxt = w_hdr_cnt_m1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_cfg_nxt   = i_data;
          w_addr_nxt  = r_ptr;
          w_wr_en_nxt = 1'b1;
          w_ptr_nxt   = r_ptr + ADDR_W'(1);
          if (r_remaining != '0) begin
            w_remaining_nxt = r_remaining - ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
      end
      S_ERR: begin
        if (i_err_clr) begin
          w_err_nxt = 1'b0;
        end
      end
      default: begin
        w_err_nxt = r_err;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr       <= '0;
      r_remaining <= '0;
      r_cfg       <= '0;
      r_addr      <= '0;
      r_wr_en     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_remaining <= w_remaining_nxt;
      r_cfg       <= w_cfg_nxt;
      r_addr      <= w_addr_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign o_ready = w_ready;
  assign o_busy  = (r_state != S_IDLE);
  assign o_cfg   = r_cfg;
  assign o_addr  = r_addr;
  assign o_wr_en = r_wr_en;
  assign o_done  = r_done;
  assign o_err   = r_err;

endmodule
